// File: rtl/idct_transpose_buf.sv
// 8x8 transpose buffer between the row and column IDCT passes: rows in, columns out.
// Define IDCT_TRANSPOSE_PINGPONG_EN for two ping-pong banks; otherwise a single bank is used.
module idct_transpose_buf #(
  parameter int N  = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] in_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N*DW-1:0] out_col,
  output logic          out_last
);

  localparam int AW = $clog2(N);
`ifdef IDCT_TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILLING,
    S_FULL,
    S_DRAINING
  } bank_state_e;

  logic [DW-1:0]   r_mem [NB][N][N];
  bank_state_e     r_state [NB];
  bank_state_e     w_nxt_state [NB];
  logic [NB-1:0]   w_full;
  logic [AW-1:0]   r_wr_row;
  logic [AW-1:0]   r_rd_col;
  logic            w_wb;
  logic            w_rb;
  logic            w_wr_fire;
  logic            w_rd_fire;
  logic            w_wr_done;
  logic            w_rd_done;
  logic [N*DW-1:0] w_col;

  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_wr_done = w_wr_fire && (r_wr_row == AW'(N-1));
  assign w_rd_done = w_rd_fire && (r_rd_col == AW'(N-1));

`ifdef IDCT_TRANSPOSE_PINGPONG_EN
  logic r_wb;
  logic r_rb;

  // Bank selects flip when a bank completes filling or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb <= 1'b0;
      r_rb <= 1'b0;
    end else begin
      if (w_wr_done) r_wb <= ~r_wb;
      if (w_rd_done) r_rb <= ~r_rb;
    end
  end

  assign w_wb = r_wb;
  assign w_rb = r_rb;
`else
  assign w_wb = 1'b0;
  assign w_rb = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_row <= '0;
      r_rd_col <= '0;
    end else begin
      if (w_wr_fire) r_wr_row <= w_wr_done ? '0 : r_wr_row + AW'(1);
      if (w_rd_fire) r_rd_col <= w_rd_done ? '0 : r_rd_col + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++)
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            r_mem[b][r][c] <= '0;
    end else if (w_wr_fire) begin
      for (int c = 0; c < N; c++)
        r_mem[w_wb][r_wr_row][c] <= in_row[c*DW +: DW];
    end
  end

  // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) r_state[b] <= S_EMPTY;
    end else begin
      for (int b = 0; b < NB; b++) r_state[b] <= w_nxt_state[b];
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      w_nxt_state[b] = r_state[b];
      case (r_state[b])
        S_EMPTY: begin
          if (w_wr_fire && (w_wb == 1'(b)))
            w_nxt_state[b] = w_wr_done ? S_FULL : S_FILLING;
        end
        S_FILLING: begin
          if (w_wr_done && (w_wb == 1'(b)))
            w_nxt_state[b] = S_FULL;
        end
        S_FULL: begin
          if (w_rd_fire && (w_rb == 1'(b)))
            w_nxt_state[b] = w_rd_done ? S_EMPTY : S_DRAINING;
        end
        S_DRAINING: begin
          if (w_rd_done && (w_rb == 1'(b)))
            w_nxt_state[b] = S_EMPTY;
        end
        default: w_nxt_state[b] = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_full = '0;
    for (int b = 0; b < NB; b++)
      w_full[b] = (r_state[b] == S_FULL) || (r_state[b] == S_DRAINING);
  end

  // Column word gathers element rd_col from every row of the read bank.
  always_comb begin
    w_col = '0;
    for (int r = 0; r < N; r++)
      w_col[r*DW +: DW] = r_mem[w_rb][r][r_rd_col];
  end

  assign in_ready  = !w_full[w_wb];
  assign out_valid = w_full[w_rb];
  assign out_col   = w_col;
  assign out_last  = out_valid && (r_rd_col == AW'(N-1));

endmodule

// File: doc/idct_transpose_buf.md
# idct_transpose_buf

8×8 transpose buffer between the row IDCT pass and the column IDCT pass. It accepts one block as eight 128-bit row words, each holding eight 16-bit intermediate results. It then emits the same block as eight 128-bit column words for the column stage. Both sides use valid/ready handshakes, and ping-pong banking lets the stage stream one word per cycle in each direction.

## Interface
- `N`, default 8: block dimension; fixed at 8 in this design.
- `DW`, default 16: element width; matches the row-stage output element width.
- `clk` in 1: clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_row` holds a valid row word.
- `in_ready` out 1: buffer can accept a row this cycle.
- `in_row` in N*DW: row r; element c sits at bits `[c*DW +: DW]`.
- `out_valid` out 1: `out_col` holds a valid column word.
- `out_ready` in 1: downstream accepts the column this cycle.
- `out_col` out N*DW: column c; element r sits at bits `[r*DW +: DW]`, and equals row r element c.
- `out_last` out 1: high with `out_valid` on column 7 of a block.

## Operation
- Storage: two banks (B0, B1) of N×N×DW registers, each with a `full` flag.
- Write pointer:
  - Signals: `wb` (bank select) and `wr_row` (0..7).
  - `in_ready = !full[wb]`.
  - On `in_valid && in_ready`: store `in_row` into `bank[wb]` row `wr_row`, then increment `wr_row`.
  - On accepting row 7: set `full[wb]`, reset `wr_row` to 0, toggle `wb`.
- Read pointer:
  - Signals: `rb` (bank select) and `rd_col` (0..7).
  - `out_valid = full[rb]`.
  - `out_col` is driven combinationally from `bank[rb]` column `rd_col`.
  - `out_last = out_valid && (rd_col == 7)`.
  - On `out_valid && out_ready`: increment `rd_col`.
  - On the column-7 handshake: clear `full[rb]`, reset `rd_col` to 0, toggle `rb`.
- Per-bank cycle: EMPTY → FILLING (first row written) → FULL (row 7 written) → DRAINING (first column taken) → EMPTY (column 7 taken).
- No arithmetic is performed; elements are moved bit-exact and sign is irrelevant.
- Boundary conditions:
  - Both banks full: `in_ready` = 0; input stalls with no data loss.
  - Both banks empty: `out_valid` = 0.
  - Same cycle, bank X frees on the column-7 handshake while bank Y completes on row 7: both take effect. The freed bank is writable next cycle.
  - Stall: while `out_valid && !out_ready`, `out_col` and `out_last` are held stable.
  - `in_valid` low mid-block: `wr_row` is held, and a partial block never raises `full`.
  - Reset mid-block: partial write and partial drain are discarded, and all pointers return to 0.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `out_last` = 0, `out_col` = 0.
  - All storage = 0, all `full` flags = 0.
  - `wb` = `rb` = 0, `wr_row` = `rd_col` = 0.
- Latency: `out_valid` rises in the cycle after the edge that accepts row 7. Column 0 is valid in that cycle.
- Throughput with banking: sustained 1 row/cycle in and 1 column/cycle out, i.e. one block per 8 cycles.
- `in_ready` depends only on registered state; there is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `IDCT_TRANSPOSE_PINGPONG_EN` defined: two banks as described above.
- `IDCT_TRANSPOSE_PINGPONG_EN` undefined: single bank (B0 only), with `wb` and `rb` tied to 0.
  - `in_ready` stays 0 from the acceptance of row 7 until the column-7 handshake completes.
  - Best-case throughput is one block per 16 cycles.
  - Latency and port behaviour are otherwise identical.

## Test plan
- Reset check: assert `rst_n` = 0 mid-frame → `in_ready` = 1, `out_valid` = 0, `out_col` = 0, `out_last` = 0 immediately, without waiting for a clock edge.
- Basic transpose: drive 8 rows with element (r,c) = r*8+c and `out_ready` held 1.
  - `out_valid` rises 1 cycle after row 7.
  - Column 3 elements r = 0..7 read 3, 11, 19, 27, 35, 43, 51, 59.
  - `out_last` is high only on column 7.
- Backpressure: drop `out_ready` for 5 cycles at column 2 → `out_col` stays equal to column 2 throughout; no column is skipped or repeated.
- Streaming (macro defined): 4 back-to-back blocks with `in_valid` = `out_ready` = 1 → `in_ready` never drops; 32 columns are output in 32 consecutive cycles after the first latency cycle.
- Bank full: hold `out_ready` = 0 and push 3 blocks → `in_ready` = 0 after row 7 of block 2. Block 3 row 0 is held until the first block drains; all data is intact.
- Single-bank build (macro undefined): 2 back-to-back blocks → `in_ready` = 0 for 8 cycles between blocks; block 2 output is correct.
